// File: rtl/if_icache.sv
// Direct-mapped blocking instruction cache between IF and the memory IF port.
// Each line holds 8 bytes and is refilled by a single 64-bit read.
// A store snoop or a fence.i flush invalidates lines.
// Optional build macro: ICACHE_BYPASS_EN (no arrays, every fetch goes to memory).
module if_icache #(
  parameter int unsigned LINES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rep_o,
  output logic [31:0] if_inst_o,
  output logic        ms_req_o,
  output logic [31:0] ms_addr_o,
  input  logic        ms_rep_i,
  input  logic [63:0] ms_rep_data_i,
  input  logic        snoop_we_i,
  input  logic [31:0] snoop_addr_i,
  input  logic        flush_i
);

  localparam int unsigned IDX  = $clog2(LINES);
  localparam int unsigned TAGW = 32 - IDX - 3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic        ms_req_q, ms_req_d;
  logic [31:0] ms_addr_q, ms_addr_d;
  logic        if_rep_q, if_rep_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        kill_q, kill_d;

  logic        hit_c;
  logic [63:0] hit_data_c;
  logic        inval_c;

`ifdef ICACHE_BYPASS_EN
  // No storage: every lookup misses and invalidation sources are ignored.
  logic unused_c;
  assign hit_c      = 1'b0;
  assign hit_data_c = '0;
  assign inval_c    = 1'b0;
  assign unused_c   = ^{snoop_we_i, snoop_addr_i, flush_i, kill_q, addr_q, if_addr_i[1:0]};
`else
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [63:0]      data_q [LINES];
  logic [IDX-1:0]   req_idx_c, fill_idx_c, snp_idx_c;
  logic [TAGW-1:0]  req_tag_c, fill_tag_c, snp_tag_c;
  logic             fill_c;
  logic             unused_c;

  assign req_idx_c  = if_addr_i[IDX+2:3];
  assign req_tag_c  = if_addr_i[31:IDX+3];
  assign fill_idx_c = addr_q[IDX+2:3];
  assign fill_tag_c = addr_q[31:IDX+3];
  assign snp_idx_c  = snoop_addr_i[IDX+2:3];
  assign snp_tag_c  = snoop_addr_i[31:IDX+3];
  assign fill_c     = (state_q == S_WAIT) && ms_rep_i;
  assign unused_c   = ^{if_addr_i[1:0], snoop_addr_i[2:0]};

  assign hit_c      = valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);
  assign hit_data_c = data_q[req_idx_c];
  // An invalidation aimed at the line currently being refilled.
  assign inval_c    = flush_i ||
                      (snoop_we_i && (snp_idx_c == fill_idx_c) && (snp_tag_c == fill_tag_c));

  // Valid update: fill, then snoop, then flush, so invalidation wins.
  always_comb begin
    valid_d = valid_q;
    if (fill_c) begin
      valid_d[fill_idx_c] = ~(kill_q | inval_c);
    end
    if (snoop_we_i && (tag_q[snp_idx_c] == snp_tag_c)) begin
      valid_d[snp_idx_c] = 1'b0;
    end
    if (flush_i) begin
      valid_d = '0;
    end
  end

  // Valid bits are the only array state that needs reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data are written on every refill; valid decides whether they count.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      tag_q[fill_idx_c]  <= fill_tag_c;
      data_q[fill_idx_c] <= ms_rep_data_i;
    end
  end
`endif

  // Next-state and registered-output computation for the fetch FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ms_req_d  = 1'b0;
    ms_addr_d = ms_addr_q;
    if_rep_d  = 1'b0;
    if_inst_d = '0;
    kill_d    = kill_q;
    case (state_q)
      S_IDLE: begin
        if (if_req_i) begin
          addr_d = if_addr_i[31:2];
          if (hit_c) begin
            if_rep_d  = 1'b1;
            if_inst_d = if_addr_i[2] ? hit_data_c[63:32] : hit_data_c[31:0];
            state_d   = S_RESP;
          end else begin
            ms_req_d  = 1'b1;
            ms_addr_d = {if_addr_i[31:3], 3'b000};
            kill_d    = 1'b0;
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        kill_d  = kill_q | inval_c;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        kill_d = kill_q | inval_c;
        if (ms_rep_i) begin
          if_rep_d  = 1'b1;
          if_inst_d = addr_q[2] ? ms_rep_data_i[63:32] : ms_rep_data_i[31:0];
          ms_addr_d = '0;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      ms_req_q  <= 1'b0;
      ms_addr_q <= '0;
      if_rep_q  <= 1'b0;
      if_inst_q <= '0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ms_req_q  <= ms_req_d;
      ms_addr_q <= ms_addr_d;
      if_rep_q  <= if_rep_d;
      if_inst_q <= if_inst_d;
      kill_q    <= kill_d;
    end
  end

  assign if_rep_o  = if_rep_q;
  assign if_inst_o = if_inst_q;
  assign ms_req_o  = ms_req_q;
  assign ms_addr_o = ms_addr_q;

endmodule

// File: tb/tb_if_icache.sv
// Self-checking bench for if_icache: scoreboard of expected fetch words,
// plus per-fetch checks of miss/hit timing and refill addresses.
module tb_if_icache;

`ifdef ICACHE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_rep_o;
  logic [31:0] if_inst_o;
  logic        ms_req_o;
  logic [31:0] ms_addr_o;
  logic        ms_rep_i;
  logic [63:0] ms_rep_data_i;
  logic        snoop_we_i;
  logic [31:0] snoop_addr_i;
  logic        flush_i;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q [$];

  if_icache #(.LINES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rep_o(if_rep_o), .if_inst_o(if_inst_o),
    .ms_req_o(ms_req_o), .ms_addr_o(ms_addr_o),
    .ms_rep_i(ms_rep_i), .ms_rep_data_i(ms_rep_data_i),
    .snoop_we_i(snoop_we_i), .snoop_addr_i(snoop_addr_i),
    .flush_i(flush_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory image: one 64-bit line per 8-byte aligned address.
  function automatic logic [63:0] line_data(input logic [31:0] a);
    logic [31:0] la;
    la = {a[31:3], 3'b000};
    if (la == 32'h10) return 64'h2222_2222_1111_1111;
    return {la ^ 32'hCAFE_0004, la ^ 32'h1234_0000};
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [63:0] d;
    d = line_data(a);
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  // Scoreboard: every reply pops one expected word.
  always @(negedge clk) begin
    if (rst_n && if_rep_o) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_rep", 64'(if_rep_o), 64'd0);
      end else begin
        check_eq("inst", 64'(if_inst_o), 64'(exp_q.pop_front()));
      end
    end
  end

  // One fetch: hit expects a reply one cycle after acceptance, miss expects
  // a refill pulse, then the bench replies after dly WAIT cycles.
  task automatic fetch(input logic [31:0] a, input bit hit_in, input int dly, input bit do_flush);
    bit exp_hit;
    exp_hit = hit_in && !BYP;
    @(negedge clk);
    if_req_i  = 1'b1;
    if_addr_i = a;
    exp_q.push_back(word_of(a));
    @(negedge clk);
    check_eq("rep_hit", 64'(if_rep_o), 64'(exp_hit));
    check_eq("ms_req", 64'(ms_req_o), 64'(!exp_hit));
    if (exp_hit) begin
      if_req_i = 1'b0;
    end else begin
      check_eq("ms_addr", 64'(ms_addr_o), 64'({a[31:3], 3'b000}));
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        flush_i = do_flush && (i == 0);
      end
      flush_i = 1'b0;
      check_eq("ms_addr_hold", 64'(ms_addr_o), 64'({a[31:3], 3'b000}));
      ms_rep_i      = 1'b1;
      ms_rep_data_i = line_data(a);
      @(negedge clk);
      ms_rep_i = 1'b0;
      if_req_i = 1'b0;
      check_eq("rep_miss", 64'(if_rep_o), 64'd1);
    end
  endtask

  task automatic snoop(input logic [31:0] a);
    @(negedge clk);
    snoop_we_i   = 1'b1;
    snoop_addr_i = a;
    @(negedge clk);
    snoop_we_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_req_i = 1'b0; if_addr_i = '0; ms_rep_i = 1'b0;
    ms_rep_data_i = '0; snoop_we_i = 1'b0; snoop_addr_i = '0; flush_i = 1'b0;
    #12;
    check_eq("rst_rep", 64'(if_rep_o), 64'd0);
    check_eq("rst_inst", 64'(if_inst_o), 64'd0);
    check_eq("rst_ms_req", 64'(ms_req_o), 64'd0);
    check_eq("rst_ms_addr", 64'(ms_addr_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss then hit on the other half of the line.
    fetch(32'h10, 1'b0, 1, 1'b0);
    fetch(32'h14, 1'b1, 0, 1'b0);

    // Conflict on index 2 with a different tag.
    fetch(32'h210, 1'b0, 2, 1'b0);
    fetch(32'h10,  1'b0, 1, 1'b0);
    fetch(32'h10,  1'b1, 0, 1'b0);

    // Snoop with matching tag kills the line; different tag does not.
    snoop(32'h14);
    fetch(32'h10, 1'b0, 1, 1'b0);
    snoop(32'h214);
    fetch(32'h10, 1'b1, 0, 1'b0);

    // Flush in WAIT: data still returned, line not installed.
    fetch(32'h40, 1'b0, 3, 1'b1);
    fetch(32'h40, 1'b0, 1, 1'b0);
    fetch(32'h44, 1'b1, 0, 1'b0);

    // Reset during WAIT abandons the miss and clears valid bits.
    @(negedge clk);
    if_req_i  = 1'b1;
    if_addr_i = 32'h80;
    @(negedge clk);
    check_eq("rm_ms_req", 64'(ms_req_o), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rm_rep", 64'(if_rep_o), 64'd0);
    check_eq("rm_inst", 64'(if_inst_o), 64'd0);
    check_eq("rm_ms_req0", 64'(ms_req_o), 64'd0);
    check_eq("rm_ms_addr", 64'(ms_addr_o), 64'd0);
    if_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ms_rep_i      = 1'b1;
    ms_rep_data_i = line_data(32'h80);
    @(negedge clk);
    ms_rep_i = 1'b0;
    check_eq("late_rep", 64'(if_rep_o), 64'd0);
    @(negedge clk);
    check_eq("late_rep2", 64'(if_rep_o), 64'd0);
    fetch(32'h40, 1'b0, 1, 1'b0);
    fetch(32'h80, 1'b0, 2, 1'b0);
    fetch(32'h84, 1'b1, 0, 1'b0);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_icache.md
# if_icache

Direct-mapped, blocking instruction cache between the IF stage and the memory simulator's IF port. It accepts 32-bit fetch requests, returns hits one cycle after acceptance, and refills misses with one 64-bit memory read covering an 8-byte line. A write-snoop input invalidates lines that MEM-stage stores modify.

## Interface
- `LINES`, 64: number of lines; power of two, 2..1024. `IDX = log2(LINES)`.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `if_req_i` input 1: fetch request, level; held with a stable `if_addr_i` until `if_rep_o`.
- `if_addr_i` input 32: fetch byte address; bits [1:0] ignored.
- `if_rep_o` output 1: one-cycle pulse; `if_inst_o` valid.
- `if_inst_o` output 32: fetched word; zero when `if_rep_o`=0.
- `ms_req_o` output 1: one-cycle refill request pulse to memory.
- `ms_addr_o` output 32: line address, `{if_addr[31:3],3'b000}`; held until reply.
- `ms_rep_i` input 1: memory reply strobe.
- `ms_rep_data_i` input 64: line data; [31:0] is the word at addr[2]=0, [63:32] is the word at addr[2]=1.
- `snoop_we_i` input 1: MEM-stage store in this cycle.
- `snoop_addr_i` input 32: store byte address.
- `flush_i` input 1: invalidate the whole cache (fence.i).

## Operation
- Index = addr[IDX+2:3]. Tag = addr[31:IDX+3]. Storage per line is a valid bit, a tag, and 64 data bits.
- FSM states:
  - IDLE: if `if_req_i`=1, latch the address and look it up. On a hit go to RESP. On a miss go to REQ.
  - REQ: `ms_req_o`=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold `ms_addr_o`. On `ms_rep_i`=1, capture the data and go to RESP.
  - RESP: `if_rep_o`=1 and `if_inst_o` = the selected 32-bit half, chosen by addr[2]. Go to IDLE.
- Fill: on `ms_rep_i` in WAIT, write data and tag, and set valid. Valid is not set if any of these occurred between the REQ cycle and that cycle, inclusive: `flush_i`, or a snoop hitting this line's index with a matching tag. The requester still receives the data.
- `if_req_i` is sampled only in IDLE. A held request is re-accepted in the IDLE cycle after RESP.
- `ms_rep_i` outside WAIT is ignored.
- Snoop: `snoop_we_i`=1 clears valid of line `snoop_addr_i[IDX+2:3]` if the tag matches. Any state, one cycle, no stall.
- Flush: clears all valid bits at the next edge, in any state. It does not abort an in-flight miss.
- Simultaneous events:
  - Snoop or flush together with a fill on the same line and edge: invalidation wins.
  - Snoop together with a hit lookup on the same line in IDLE: the hit is still served with the old data. The next request misses.
- Reset, asynchronous, any state: FSM goes to IDLE, all valid bits are cleared, all outputs go to 0, and a pending miss is abandoned.

## Timing
- Hit: request accepted at edge N; `if_rep_o`=1 in cycle N+1.
- Miss: accept at edge N; `ms_req_o`=1 in cycle N+1; WAIT from N+2. A reply in cycle M (M≥N+2) gives `if_rep_o` in cycle M+1.
- Minimum miss latency is 3 cycles from acceptance.
- Throughput is one hit per 2 cycles: IDLE, RESP.
- All outputs are registered. Reset values: `if_rep_o`=0, `if_inst_o`=0, `ms_req_o`=0, `ms_addr_o`=0.

## Configuration
- `ICACHE_BYPASS_EN`:
  - Defined: the data, tag and valid arrays are not built. Every request takes the miss path and nothing is filled. Snoop and flush inputs are ignored. Latency is always the miss latency.
  - Undefined: normal cache behaviour as above.

## Test plan
- Cold miss then hit:
  - Request 0x0000_0010: `ms_req_o` pulses with `ms_addr_o`=0x10. Reply 0x2222_2222_1111_1111 gives `if_inst_o`=0x1111_1111.
  - Then request 0x14: `if_inst_o`=0x2222_2222 one cycle after acceptance, with no `ms_req_o`.
- Conflict, LINES=64:
  - Fill 0x10, then request 0x210 (same index, different tag): miss and refill.
  - Re-request 0x10: misses again.
- Snoop:
  - After filling 0x10, `snoop_we_i`=1 with `snoop_addr_i`=0x14: the next request to 0x10 misses.
  - A snoop to 0x214 leaves 0x10 a hit.
- Flush during WAIT:
  - Requester receives the reply data.
  - A subsequent request to the same address misses.
- Reset mid-miss:
  - Drop `rst_n` in WAIT: all outputs are 0 immediately.
  - A late `ms_rep_i` after release produces no `if_rep_o`.
  - The next request misses.
- `ICACHE_BYPASS_EN`: two consecutive requests to 0x10 each produce a `ms_req_o` pulse.
